// File: rtl/dmem_responder.sv
// dmem_responder: data memory for a simple processor. Word RAM plus a small
// MMIO block (LED register, free-running timer with compare/match, status).
// Optional timer build: define DMEM_RESPONDER_TIMER_EN to implement COUNT,
// CMP, match and irq; without it those registers read 0 and no timer flops exist.
module dmem_responder #(
  parameter int DEPTH     = 64,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  leds,
  output logic        irq,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] A_LED    = 32'hFFFF_FFF0;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_FFF4;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FFF8;
  localparam logic [31:0] A_CMP    = 32'hFFFF_FFFC;

  logic [31:0]   r_mem [DEPTH];
  logic [7:0]    r_leds;
  logic          r_err;

  logic          w_mmio;
  logic          w_misal;
  logic          w_ram_we;
  logic          w_wr_led;
  logic          w_wr_sts;
  logic          w_err_set;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_count;
  logic [31:0]   w_cmp;
  logic          w_match;

  // Address decode and write strobes; misaligned accesses never reach storage.
  always_comb begin
    w_mmio    = (addr[31:16] == 16'hFFFF);
    w_misal   = (addr[1:0] != 2'b00);
    w_idx     = addr[AW+1:2];
    w_ram_we  = memwrite && !w_mmio && !w_misal;
    w_wr_led  = memwrite && (addr == A_LED);
    w_wr_sts  = memwrite && (addr == A_STATUS);
    w_err_set = memwrite && w_misal;
  end

  // RAM write port; no reset on contents, and a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (w_ram_we && !reset) r_mem[w_idx] <= writedata;
  end

  // LED register and sticky error flag (set wins over write-1-to-clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_led) r_leds <= writedata[7:0];
      r_err <= w_err_set || (r_err && !(w_wr_sts && writedata[0]));
    end
  end

`ifdef DMEM_RESPONDER_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;
  logic        w_wr_cnt;
  logic        w_wr_cmp;
  logic [31:0] w_count_nxt;
  logic [31:0] w_cmp_nxt;
  logic        w_match_set;

  // Timer next state; match is judged on the value count takes at this edge,
  // so irq rises in the same cycle COUNT first reads equal to CMP.
  always_comb begin
    w_wr_cnt    = memwrite && (addr == A_COUNT);
    w_wr_cmp    = memwrite && (addr == A_CMP);
    w_count_nxt = w_wr_cnt ? writedata : (r_count + 32'd1);
    w_cmp_nxt   = w_wr_cmp ? writedata : r_cmp;
    w_match_set = (w_cmp_nxt != 32'd0) && (w_count_nxt == w_cmp_nxt);
  end

  // Timer registers; a COUNT write overrides the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_cmp   <= '0;
      r_match <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_cmp   <= w_cmp_nxt;
      r_match <= w_match_set || (r_match && !(w_wr_sts && writedata[1]));
    end
  end

  assign w_count = r_count;
  assign w_cmp   = r_cmp;
  assign w_match = r_match;
`else
  assign w_count = 32'd0;
  assign w_cmp   = 32'd0;
  assign w_match = 1'b0;
`endif

  // Combinational read mux: misaligned reads and unmapped MMIO return 0.
  always_comb begin
    readdata = 32'd0;
    if (!w_misal) begin
      if (w_mmio) begin
        case (addr)
          A_LED:    readdata = {24'd0, r_leds};
          A_COUNT:  readdata = w_count;
          A_STATUS: readdata = {30'd0, w_match, r_err};
          A_CMP:    readdata = w_cmp;
          default:  readdata = 32'd0;
        endcase
      end else begin
        readdata = r_mem[w_idx];
      end
    end
  end

  assign leds = r_leds;
  assign err  = r_err;
  assign irq  = w_match;

endmodule
